// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back front end.
// Register geometry constants are shared with register_file.
package regfile_writeback_pkg;

  localparam int REG_DATA_W = 64;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int REG_ZERO   = 0;

  // Identifies which result source won the write port on a given cycle.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  // True when a write destination targets the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ADDR_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO buffering one write-back source (address + data per entry).
// Depth must be a power of two so pointers wrap naturally.
module wb_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = storage[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until the matching count says otherwise.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: buffers ALU and load-return
// results, round-robin arbitrates one write per cycle onto the register file
// write port, and tracks pending destinations in a busy scoreboard.
// Optional feature macro: WB_FORWARDING_EN (adds write-port forwarding compare).
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic [0:DATA_W-1] alu_wb_data,
  input  logic              mem_wb_valid,
  output logic              mem_wb_ready,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [0:DATA_W-1] mem_wb_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [0:DATA_W-1] rf_rd_data
`ifdef WB_FORWARDING_EN
  ,
  input  logic [ADDR_W-1:0] fwd_ra_addr,
  input  logic [ADDR_W-1:0] fwd_rb_addr,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [0:DATA_W-1] fwd_data
`endif
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic             alu_full, alu_empty, mem_full, mem_empty;
  logic             alu_push, mem_push;
  logic             alu_pop, mem_pop;
  logic [ENT_W-1:0] alu_dout, mem_dout;

  wb_src_e          last_grant;
  logic             grant_mem;

  logic [ENT_W-1:0]  entry_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [0:DATA_W-1] data_p0;
  logic              pop_p0;
  logic              vld_p0;

  logic [REG_COUNT-1:0] busy_next;

  // Ready comes straight from occupancy, so a full buffer refuses even on a popping cycle.
  assign alu_wb_ready = reset && !alu_full;
  assign mem_wb_ready = reset && !mem_full;
  assign alu_push     = alu_wb_valid && alu_wb_ready;
  assign mem_push     = mem_wb_valid && mem_wb_ready;

  wb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (alu_push),
    .din   ({alu_wb_addr, alu_wb_data}),
    .pop   (alu_pop),
    .dout  (alu_dout),
    .full  (alu_full),
    .empty (alu_empty)
  );

  wb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (mem_push),
    .din   ({mem_wb_addr, mem_wb_data}),
    .pop   (mem_pop),
    .dout  (mem_dout),
    .full  (mem_full),
    .empty (mem_empty)
  );

  // Round-robin arbitration: a lone non-empty source wins; on contest the source not granted last wins.
  always_comb begin
    grant_mem = 1'b0;
    alu_pop   = 1'b0;
    mem_pop   = 1'b0;
    if (reset) begin
      grant_mem = !mem_empty && (alu_empty || last_grant == SRC_ALU);
      mem_pop   = grant_mem;
      alu_pop   = !alu_empty && !grant_mem;
    end
  end

  // ---- stage p0: popped entry selected from the winning buffer ----
  assign entry_p0 = grant_mem ? mem_dout : alu_dout;
  assign addr_p0  = entry_p0[ENT_W-1 -: ADDR_W];
  assign data_p0  = entry_p0[DATA_W-1:0];
  assign pop_p0   = alu_pop || mem_pop;
  assign vld_p0   = pop_p0 && !is_zero_reg(addr_p0);

  // Remember the last granted source; reset leaves ALU as "last" so mem wins the first contest.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= SRC_ALU;
    end else if (pop_p0) begin
      last_grant <= grant_mem ? SRC_MEM : SRC_ALU;
    end
  end

  // ---- stage p1: register-file write port register ----
  // Writes to r0 are dropped; address/data hold their last committed values when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_write_en <= 1'b0;
      rf_rd_addr  <= '0;
      rf_rd_data  <= '0;
    end else begin
      rf_write_en <= vld_p0;
      if (vld_p0) begin
        rf_rd_addr <= addr_p0;
        rf_rd_data <= data_p0;
      end
    end
  end

  // Scoreboard update: commit clears, issue sets afterwards so a same-edge set wins.
  always_comb begin
    busy_next = busy_mask;
    if (vld_p0) busy_next[addr_p0] = 1'b0;
    if (issue_valid && !is_zero_reg(issue_addr)) busy_next[issue_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  // Pending-destination register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

`ifdef WB_FORWARDING_EN
  // The register file holds its read outputs during a write, so readers of the
  // register being written take the value from the write port instead.
  assign fwd_a_hit = reset && rf_write_en && !is_zero_reg(rf_rd_addr) && (rf_rd_addr == fwd_ra_addr);
  assign fwd_b_hit = reset && rf_write_en && !is_zero_reg(rf_rd_addr) && (rf_rd_addr == fwd_rb_addr);
  assign fwd_data  = rf_rd_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        alu_wb_valid;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_addr;
  logic [0:63] alu_wb_data;
  logic        mem_wb_valid;
  logic        mem_wb_ready;
  logic [4:0]  mem_wb_addr;
  logic [0:63] mem_wb_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [31:0] busy_mask;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [0:63] rf_rd_data;
`ifdef WB_FORWARDING_EN
  logic [4:0]  fwd_ra_addr;
  logic [4:0]  fwd_rb_addr;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [0:63] fwd_data;
`endif

  regfile_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ready (mem_wb_ready),
    .mem_wb_addr  (mem_wb_addr),
    .mem_wb_data  (mem_wb_data),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .busy_mask    (busy_mask),
    .rf_write_en  (rf_write_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data)
`ifdef WB_FORWARDING_EN
    ,
    .fwd_ra_addr  (fwd_ra_addr),
    .fwd_rb_addr  (fwd_rb_addr),
    .fwd_a_hit    (fwd_a_hit),
    .fwd_b_hit    (fwd_b_hit),
    .fwd_data     (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per source, last-granted source, scoreboard bits, write port.
  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        aq[$];
  ent_t        mq[$];
  bit          m_last_mem;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;

  bit          a_acc, m_acc;
  bit          saw_full;
  logic [4:0]  log_q[$];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registered outputs.
  task automatic cycle();
    ent_t e;
    bit   gm, ga;
    logic exp_ar, exp_mr;
    #1;
    exp_ar = reset && (aq.size() < DEPTH);
    exp_mr = reset && (mq.size() < DEPTH);
    check("alu_ready", alu_wb_ready, exp_ar);
    check("mem_ready", mem_wb_ready, exp_mr);
    if (reset && !exp_ar) saw_full = 1'b1;
    a_acc = reset && alu_wb_valid && exp_ar;
    m_acc = reset && mem_wb_valid && exp_mr;
`ifdef WB_FORWARDING_EN
    check("fwd_a_hit", fwd_a_hit, reset && m_we && m_addr != 0 && m_addr == fwd_ra_addr);
    check("fwd_b_hit", fwd_b_hit, reset && m_we && m_addr != 0 && m_addr == fwd_rb_addr);
    if (reset && m_we) check("fwd_data", fwd_data, m_data);
`endif
    @(posedge clk);
    if (!reset) begin
      aq.delete();
      mq.delete();
      m_busy = '0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_last_mem = 1'b0;
    end else begin
      gm = (mq.size() > 0) && (aq.size() == 0 || !m_last_mem);
      ga = (aq.size() > 0) && !gm;
      m_we = 1'b0;
      if (gm || ga) begin
        if (gm) e = mq.pop_front();
        else    e = aq.pop_front();
        m_last_mem = gm;
        if (e.a != 0) begin
          m_we = 1'b1;
          m_addr = e.a;
          m_data = e.d;
          m_busy[e.a] = 1'b0;
        end
      end
      if (a_acc) aq.push_back('{a: alu_wb_addr, d: alu_wb_data});
      if (m_acc) mq.push_back('{a: mem_wb_addr, d: mem_wb_data});
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
    #1;
    check("rf_write_en", rf_write_en, m_we);
    check("rf_rd_addr", rf_rd_addr, m_addr);
    check("rf_rd_data", rf_rd_data, m_data);
    check("busy_mask", busy_mask, m_busy);
    log_q.push_back(rf_write_en ? rf_rd_addr : 5'd0);
  endtask

  // Random source driver; a valid that was not accepted is held with unchanged payload.
  task automatic drive(input int pct_valid);
    if (!alu_wb_valid || a_acc) begin
      alu_wb_valid = ($urandom_range(0, 99) < pct_valid);
      alu_wb_addr  = 5'($urandom_range(0, 15));
      alu_wb_data  = {$urandom, $urandom};
    end
    if (!mem_wb_valid || m_acc) begin
      mem_wb_valid = ($urandom_range(0, 99) < pct_valid);
      mem_wb_addr  = 5'($urandom_range(0, 15));
      mem_wb_data  = {$urandom, $urandom};
    end
    issue_valid = 1'($urandom_range(0, 1));
    issue_addr  = 5'($urandom_range(0, 31));
`ifdef WB_FORWARDING_EN
    fwd_ra_addr = ($urandom_range(0, 1) != 0) ? m_addr : 5'($urandom_range(0, 15));
    fwd_rb_addr = 5'($urandom_range(0, 15));
`endif
  endtask

  int          exp_order[10] = '{0, 5, 1, 6, 2, 7, 3, 8, 4, 0};
  logic [31:0] busy_before;

  initial begin
    reset = 1'b0;
    alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
    mem_wb_valid = 1'b0; mem_wb_addr = '0; mem_wb_data = '0;
    issue_valid = 1'b0;  issue_addr = '0;
    a_acc = 1'b0; m_acc = 1'b0; saw_full = 1'b0;
`ifdef WB_FORWARDING_EN
    fwd_ra_addr = '0; fwd_rb_addr = '0;
`endif
    cycle();
    cycle();
    reset = 1'b1;

    // ALU only: issue r3, then push (r3, 0x1111); commit after the second edge.
    issue_valid = 1'b1; issue_addr = 5'd3;
    cycle();
    issue_valid = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 64'h1111;
    cycle();
    alu_wb_valid = 1'b0;
    check("t1_en_after_push", rf_write_en, 1'b0);
    check("t1_busy3_before", busy_mask[3], 1'b1);
    cycle();
    check("t1_en", rf_write_en, 1'b1);
    check("t1_addr", rf_rd_addr, 5'd3);
    check("t1_data", rf_rd_data, 64'h1111);
    check("t1_busy3_clear", busy_mask[3], 1'b0);
    cycle();
    check("t1_idle_en", rf_write_en, 1'b0);
    check("t1_hold_data", rf_rd_data, 64'h1111);

    // Contest after reset: mem first, strict alternation, no bubbles.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      alu_wb_valid = (i < 4);
      alu_wb_addr  = 5'(i + 1);
      alu_wb_data  = 64'(32'hA000 + i);
      mem_wb_valid = (i < 4);
      mem_wb_addr  = 5'(i + 5);
      mem_wb_data  = 64'(32'hB000 + i);
      cycle();
    end
    for (int i = 0; i < 10; i++) check("t2_order", log_q[i], 5'(exp_order[i]));

    // Full: both sources push every cycle so buffers fill; held valids must not be lost.
    saw_full = 1'b0;
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(100);
      cycle();
    end
    check("t3_saw_full", saw_full, 1'b1);
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0; issue_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("t3_drained_en", rf_write_en, 1'b0);

    // r0 write is popped and dropped; scoreboard unchanged.
    busy_before = busy_mask;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 64'hFFFF;
    cycle();
    alu_wb_valid = 1'b0;
    cycle();
    check("t4_r0_en", rf_write_en, 1'b0);
    cycle();
    check("t4_r0_busy", busy_mask, busy_before);

    // Set/clear race on r9: re-issue on the commit edge keeps the bit set.
    issue_valid = 1'b1; issue_addr = 5'd9;
    cycle();
    issue_valid = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd9; alu_wb_data = 64'h9999;
    cycle();
    alu_wb_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd9;
    cycle();
    issue_valid = 1'b0;
    check("t5_en", rf_write_en, 1'b1);
    check("t5_addr", rf_rd_addr, 5'd9);
    check("t5_busy9", busy_mask[9], 1'b1);

    // Reset mid-flight with entries queued.
    for (int i = 0; i < 2; i++) begin
      alu_wb_valid = 1'b1; alu_wb_addr = 5'(10 + i); alu_wb_data = 64'(32'hC0 + i);
      mem_wb_valid = 1'b1; mem_wb_addr = 5'(12 + i); mem_wb_data = 64'(32'hD0 + i);
`ifdef WB_FORWARDING_EN
      fwd_ra_addr = m_addr;
`endif
      cycle();
    end
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
    reset = 1'b0;
    cycle();
    check("t6_en", rf_write_en, 1'b0);
    check("t6_addr", rf_rd_addr, 5'd0);
    check("t6_data", rf_rd_data, 64'd0);
    check("t6_busy", busy_mask, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_empty_en", rf_write_en, 1'b0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      drive(70);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
